z80_bus_ctrl: RTL and testbench
===============================

# z80_bus_ctrl

Parametrised bus controller between the tv80n core and the rest of the system. It contains:
- a configurable reset stretcher;
- Z80 cycle decode;
- per-space wait-state insertion;
- single-pulse memory/IO write and IO read strobes;
- a maskable N-source interrupt controller that supplies IM2 vectors during interrupt acknowledge.

It replaces the ad-hoc combinational `{iorq_n,rd_n,wr_n}` data-bus mux and the fixed 8-cycle reset counter in the top level.

## Interface
Parameters:
- RST_HOLD, 8: cycles core_reset_n is held low after any reset request (≥1).
- N_IRQ, 4: interrupt sources (1–8).
- IRQ_VEC_BASE, 8'h80: IM2 vector for source 0. Source i uses IRQ_VEC_BASE + 2*i, mod 256.
- IRQ_PORT, 8'hF0: IO port (A[7:0]) of the interrupt controller. Write sets mask; read returns pending.
- MEM_WAIT, 0: wait states per memory cycle (0–15).
- IO_WAIT, 1: wait states per IO/INTA cycle (0–15).

Ports:
- clk_25mhz  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- btn_rst_n  in  1  external reset request, active low, pre-synchronised.
- core_reset_n  out  1  to tv80n reset_n.
- mreq_n, iorq_n, rd_n, wr_n, m1_n  in  1 each  from tv80n.
- A  in  16  address bus.
- cpu_do  in  8  CPU write data.
- cpu_di  out  8  CPU read data.
- wait_n  out  1  to tv80n wait_n.
- int_n  out  1  to tv80n int_n.
- mem_we  out  1  one-cycle RAM write pulse.
- mem_rdata  in  8  RAM read data.
- io_rd, io_wr  out  1 each  one-cycle IO strobes. Never asserted for IRQ_PORT.
- io_rdata  in  8  external IO read data.
- irq_req  in  N_IRQ  level interrupt requests.

## Operation
Cycle type is decoded combinationally every cycle, in this priority order:
- INTA: !iorq_n & !m1_n.
- IO_RD: !iorq_n & !rd_n.
- IO_WR: !iorq_n & !wr_n.
- MEM_RD: !mreq_n & !rd_n.
- MEM_WR: !mreq_n & !wr_n.
- Otherwise IDLE.

Access start is detected when the registered cycle type differs from the current type and the current type is not IDLE.

Wait-state counter:
- Loads MEM_WAIT (memory cycles) or IO_WAIT (IO/INTA) at access start.
- wait_n = 0 while the count is nonzero; the count decrements each cycle.
- With wait count 0, wait_n never falls.

Strobes:
- mem_we, io_wr, io_rd pulse exactly once per access, in the first cycle in which the access is active and the count is 0.
- cpu_do is valid at that point.
- A write held for many cycles produces one pulse.

cpu_di mux (combinational):
- MEM_RD: mem_rdata.
- IO_RD to IRQ_PORT: zero-extended pending.
- IO_RD to other ports: io_rdata.
- INTA: the latched vector.
- Otherwise 8'hFF.

Reset stretcher:
- A down-counter loads RST_HOLD on reset or !btn_rst_n.
- core_reset_n = 0 while the count is nonzero; it decrements to 0.

Interrupt controller:
- pending[i] is set on a rising edge of irq_req[i] (registered previous value).
- mask is written by IO_WR to IRQ_PORT with cpu_do[N_IRQ-1:0].
- int_n = ~|(pending & mask).
- At INTA start, the lowest set index of pending&mask is latched as the vector source.
- When INTA ends (type leaves INTA), that pending bit clears.
- A new edge on the same bit in the clearing cycle wins: the bit stays set.
- If pending&mask is empty at INTA start, the vector is IRQ_VEC_BASE and nothing clears.

## Timing
Reset values:
- core_reset_n 0, wait_n 1, int_n 1.
- mem_we, io_rd, io_wr 0.
- pending 0, mask 0, all counters 0, previous irq_req 0.
- Stretcher count is RST_HOLD.

Latencies:
- core_reset_n rises RST_HOLD cycles after the last cycle of reset or btn_rst_n low.
- wait_n falls combinationally in the access-start cycle and stays low for exactly MEM_WAIT/IO_WAIT cycles.
- Strobe pulse lands in the cycle after wait_n returns high. With zero waits it lands in the start cycle.
- int_n deasserts the cycle after a pending bit clears or a mask write takes effect.

Boundary conditions:
- Reset mid-access drops all strobes and the wait count immediately.
- An access ending early (strobe deasserts during waits) cancels the count with no pulse.

## Structure
- Shared package z80_bus_pkg holds:
  - the cycle_t enum (IDLE, MEM_RD, MEM_WR, IO_RD, IO_WR, INTA);
  - the default IRQ_PORT and IRQ_VEC_BASE constants.
- Sub-module z80_irq_ctrl holds the edge detect, pending, mask, priority encoder and vector latch.
- The rest is flat in z80_bus_ctrl.

## Test plan
- Reset release with RST_HOLD=8 -> core_reset_n rises exactly 8 cycles later. btn_rst_n pulse mid-run -> reload and hold 8 again.
- MEM_WR held 5 cycles, MEM_WAIT=0 -> one mem_we pulse in the first cycle, wait_n stays 1.
- IO_RD port 0x10, IO_WAIT=2 -> wait_n low 2 cycles, io_rd pulses once in the 3rd cycle, cpu_di=io_rdata.
- Write 0x0F to IRQ_PORT, edges on irq_req[2] and [1] -> int_n=0. INTA -> cpu_di=0x82; after INTA pending=0x4, int_n stays 0. Second INTA -> 0x84.
- mask=0, edge on irq_req[0] -> int_n stays 1, IRQ_PORT read returns 0x01.
- Edge on irq_req[1] in the same cycle its INTA ends -> pending[1] remains 1.

Source files
------------

// File: rtl/z80_bus_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | z80_bus_pkg : cycle types, defaults and decode shared by the bus ctrl |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package z80_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MEM_RD = 3'd1,
    MEM_WR = 3'd2,
    IO_RD  = 3'd3,
    IO_WR  = 3'd4,
    INTA   = 3'd5
  } cycle_t;

  localparam logic [7:0] c_IRQ_PORT_DEFAULT     = 8'hF0;
  localparam logic [7:0] c_IRQ_VEC_BASE_DEFAULT = 8'h80;

  // INTA must win over IO_RD/IO_WR because the core drives iorq_n with m1_n.
  function automatic cycle_t decode_cycle(input logic mreq_n, input logic iorq_n,
                                          input logic rd_n, input logic wr_n,
                                          input logic m1_n);
    cycle_t c;
    if (!iorq_n && !m1_n)      c = INTA;
    else if (!iorq_n && !rd_n) c = IO_RD;
    else if (!iorq_n && !wr_n) c = IO_WR;
    else if (!mreq_n && !rd_n) c = MEM_RD;
    else if (!mreq_n && !wr_n) c = MEM_WR;
    else                       c = IDLE;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/z80_irq_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | z80_irq_ctrl : edge-latched, maskable interrupts with IM2 vectors     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module z80_irq_ctrl
  import z80_bus_pkg::*;
#(
  parameter int         N_IRQ        = 4,
  parameter logic [7:0] IRQ_VEC_BASE = c_IRQ_VEC_BASE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] i_irq_req,
  input  logic             i_mask_we,
  input  logic [N_IRQ-1:0] i_mask_wdata,
  input  logic             i_inta_start,
  input  logic             i_inta_end,
  output logic [N_IRQ-1:0] o_pending,
  output logic             o_int_n,
  output logic [7:0]       o_vector
);

  logic [N_IRQ-1:0] r_irq_prev;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_mask;
  logic [2:0]       r_src;
  logic             r_src_valid;
  logic [7:0]       r_vector;

  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_active;
  logic [N_IRQ-1:0] w_clear;
  logic [2:0]       w_idx;
  logic             w_any;
  logic [7:0]       w_new_vec;

  assign w_rise   = i_irq_req & ~r_irq_prev;
  assign w_active = r_pending & r_mask;
  assign w_any    = |w_active;

  always_comb begin
    w_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_active[i]) w_idx = 3'(i);
    end
  end

  assign w_new_vec = w_any ? (IRQ_VEC_BASE + {4'b0000, w_idx, 1'b0}) : IRQ_VEC_BASE;

  always_comb begin
    w_clear = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      w_clear[i] = i_inta_end && r_src_valid && (r_src == 3'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_prev  <= '0;
      r_pending   <= '0;
      r_mask      <= '0;
      r_src       <= '0;
      r_src_valid <= 1'b0;
      r_vector    <= IRQ_VEC_BASE;
    end else begin
      r_irq_prev <= i_irq_req;
      // A fresh edge in the clearing cycle must survive the acknowledge.
      r_pending  <= (r_pending & ~w_clear) | w_rise;
      if (i_mask_we) r_mask <= i_mask_wdata;
      if (i_inta_start) begin
        r_src       <= w_idx;
        r_src_valid <= w_any;
        r_vector    <= w_new_vec;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_int_n   = ~|w_active;
  // Bypass the latch in the start cycle so the vector is on the bus immediately.
  assign o_vector  = i_inta_start ? w_new_vec : r_vector;

endmodule
`default_nettype wire

// File: rtl/z80_bus_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | z80_bus_ctrl : tv80n reset stretch, cycle decode, waits, strobes, IRQ |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module z80_bus_ctrl
  import z80_bus_pkg::*;
#(
  parameter int         RST_HOLD     = 8,
  parameter int         N_IRQ        = 4,
  parameter logic [7:0] IRQ_VEC_BASE = c_IRQ_VEC_BASE_DEFAULT,
  parameter logic [7:0] IRQ_PORT     = c_IRQ_PORT_DEFAULT,
  parameter int         MEM_WAIT     = 0,
  parameter int         IO_WAIT      = 1
) (
  input  logic             clk_25mhz,
  input  logic             reset,
  input  logic             btn_rst_n,
  output logic             core_reset_n,
  input  logic             mreq_n,
  input  logic             iorq_n,
  input  logic             rd_n,
  input  logic             wr_n,
  input  logic             m1_n,
  input  logic [15:0]      A,
  input  logic [7:0]       cpu_do,
  output logic [7:0]       cpu_di,
  output logic             wait_n,
  output logic             int_n,
  output logic             mem_we,
  input  logic [7:0]       mem_rdata,
  output logic             io_rd,
  output logic             io_wr,
  input  logic [7:0]       io_rdata,
  input  logic [N_IRQ-1:0] irq_req
);

  localparam int c_RW = $clog2(RST_HOLD + 1);

  cycle_t           w_cyc;
  cycle_t           r_cyc;
  logic [3:0]       r_wait;
  logic             r_done;
  logic [c_RW-1:0]  r_rst_cnt;

  logic             w_start;
  logic             w_is_io;
  logic [3:0]       w_load;
  logic [3:0]       w_cnt;
  logic             w_fire;
  logic             w_irq_port;
  logic             w_mask_we;
  logic             w_inta_start;
  logic             w_inta_end;
  logic [N_IRQ-1:0] w_pending;
  logic [7:0]       w_pend8;
  logic [7:0]       w_vector;
  logic             w_unused;

  assign w_cyc      = decode_cycle(mreq_n, iorq_n, rd_n, wr_n, m1_n);
  assign w_start    = (w_cyc != r_cyc) && (w_cyc != IDLE);
  assign w_is_io    = (w_cyc == IO_RD) || (w_cyc == IO_WR) || (w_cyc == INTA);
  assign w_load     = w_is_io ? 4'(IO_WAIT) : 4'(MEM_WAIT);
  // The counter register lags by a cycle, so the start cycle uses the load value.
  assign w_cnt      = w_start ? w_load : r_wait;
  assign w_fire     = !reset && (w_cyc != IDLE) && (w_cnt == 4'd0) && (w_start || !r_done);
  assign w_irq_port = (A[7:0] == IRQ_PORT);

  assign wait_n = reset || (w_cyc == IDLE) || (w_cnt == 4'd0);
  assign mem_we = w_fire && (w_cyc == MEM_WR);
  assign io_rd  = w_fire && (w_cyc == IO_RD) && !w_irq_port;
  assign io_wr  = w_fire && (w_cyc == IO_WR) && !w_irq_port;

  assign w_mask_we    = w_fire && (w_cyc == IO_WR) && w_irq_port;
  assign w_inta_start = w_start && (w_cyc == INTA);
  assign w_inta_end   = (r_cyc == INTA) && (w_cyc != INTA);

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      r_cyc  <= IDLE;
      r_wait <= 4'd0;
      r_done <= 1'b0;
    end else begin
      r_cyc <= w_cyc;
      if (w_cyc == IDLE) begin
        r_wait <= 4'd0;
        r_done <= 1'b0;
      end else begin
        r_wait <= (w_cnt != 4'd0) ? (w_cnt - 4'd1) : 4'd0;
        r_done <= (w_start ? 1'b0 : r_done) | w_fire;
      end
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset || !btn_rst_n) begin
      r_rst_cnt <= c_RW'(RST_HOLD);
    end else if (r_rst_cnt != '0) begin
      r_rst_cnt <= r_rst_cnt - c_RW'(1);
    end
  end

  assign core_reset_n = (r_rst_cnt == '0);

  z80_irq_ctrl #(
    .N_IRQ        (N_IRQ),
    .IRQ_VEC_BASE (IRQ_VEC_BASE)
  ) u_irq (
    .clk          (clk_25mhz),
    .rst          (reset),
    .i_irq_req    (irq_req),
    .i_mask_we    (w_mask_we),
    .i_mask_wdata (cpu_do[N_IRQ-1:0]),
    .i_inta_start (w_inta_start),
    .i_inta_end   (w_inta_end),
    .o_pending    (w_pending),
    .o_int_n      (int_n),
    .o_vector     (w_vector)
  );

  always_comb begin
    w_pend8 = '0;
    w_pend8[N_IRQ-1:0] = w_pending;
  end

  always_comb begin
    cpu_di = 8'hFF;
    case (w_cyc)
      MEM_RD:  cpu_di = mem_rdata;
      IO_RD:   cpu_di = w_irq_port ? w_pend8 : io_rdata;
      INTA:    cpu_di = w_vector;
      default: cpu_di = 8'hFF;
    endcase
  end

  assign w_unused = ^{A[15:8], cpu_do};

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_z80_bus_ctrl : vector table + scoreboard bench for z80_bus_ctrl    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_z80_bus_ctrl;

  // {mreq_n, iorq_n, rd_n, wr_n, m1_n}
  localparam logic [4:0] C_IDLE = 5'b11111;
  localparam logic [4:0] C_MRD  = 5'b01011;
  localparam logic [4:0] C_MWR  = 5'b01101;
  localparam logic [4:0] C_IORD = 5'b10011;
  localparam logic [4:0] C_IOWR = 5'b10101;
  localparam logic [4:0] C_INTA = 5'b10110;

  typedef struct {
    int          idx;
    string       nm;
    logic [4:0]  ctl;
    logic [15:0] a;
    logic [7:0]  dout;
    logic [3:0]  irq;
    logic [4:0]  exp_o;   // {wait_n, mem_we, io_rd, io_wr, int_n}
    logic [7:0]  exp_di;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, btn_rst_n, core_reset_n;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n;
  logic [15:0] A;
  logic [7:0]  cpu_do, cpu_di, mem_rdata, io_rdata;
  logic        wait_n, int_n, mem_we, io_rd, io_wr;
  logic [3:0]  irq_req;

  int n_pass = 0;
  int n_total = 0;
  vec_t tbl[$];
  vec_t sb[$];

  z80_bus_ctrl #(
    .RST_HOLD(8), .N_IRQ(4), .IRQ_VEC_BASE(8'h80), .IRQ_PORT(8'hF0),
    .MEM_WAIT(0), .IO_WAIT(2)
  ) dut (
    .clk_25mhz(clk), .reset(reset), .btn_rst_n(btn_rst_n), .core_reset_n(core_reset_n),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .A(A), .cpu_do(cpu_do), .cpu_di(cpu_di), .wait_n(wait_n), .int_n(int_n),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .io_rd(io_rd), .io_wr(io_wr),
    .io_rdata(io_rdata), .irq_req(irq_req)
  );

  always #5 clk = ~clk;

  function automatic void add(string nm, logic [4:0] ctl, logic [15:0] a, logic [7:0] dout,
                              logic [3:0] irq, logic [4:0] eo, logic [7:0] di);
    vec_t v;
    v.idx = tbl.size(); v.nm = nm; v.ctl = ctl; v.a = a; v.dout = dout;
    v.irq = irq; v.exp_o = eo; v.exp_di = di;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", nm, act, exp);
  endtask

  task automatic apply(input vec_t v);
    {mreq_n, iorq_n, rd_n, wr_n, m1_n} = v.ctl;
    A = v.a; cpu_do = v.dout; irq_req = v.irq;
    sb.push_back(v);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every driven vector is checked at the following falling edge.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      vec_t e;
      logic [4:0] act;
      e = sb.pop_front();
      act = {wait_n, mem_we, io_rd, io_wr, int_n};
      n_total++;
      if (act === e.exp_o) n_pass++;
      else $display("FAIL %s row %0d: {wait_n,mem_we,io_rd,io_wr,int_n} got %b expected %b",
                    e.nm, e.idx, act, e.exp_o);
      n_total++;
      if (cpu_di === e.exp_di) n_pass++;
      else $display("FAIL %s row %0d cpu_di: got %02h expected %02h", e.nm, e.idx, cpu_di, e.exp_di);
    end
  end

  initial begin
    reset = 1'b1; btn_rst_n = 1'b1;
    {mreq_n, iorq_n, rd_n, wr_n, m1_n} = C_IDLE;
    A = '0; cpu_do = '0; irq_req = '0;
    mem_rdata = 8'h3C; io_rdata = 8'hA7;

    // ---------------- vector table ----------------
    add("memwr_first", C_MWR, 16'h1234, 8'h5A, 4'h0, 5'b11001, 8'hFF);
    for (int i = 0; i < 4; i++) add("memwr_hold", C_MWR, 16'h1234, 8'h5A, 4'h0, 5'b10001, 8'hFF);
    add("idle", C_IDLE, 16'h0, 8'h0, 4'h0, 5'b10001, 8'hFF);
    add("memrd", C_MRD, 16'h2000, 8'h0, 4'h0, 5'b10001, 8'h3C);
    add("memrd", C_MRD, 16'h2000, 8'h0, 4'h0, 5'b10001, 8'h3C);
    add("memwr_b2b", C_MWR, 16'h2000, 8'h11, 4'h0, 5'b11001, 8'hFF);
    add("memwr_b2b", C_MWR, 16'h2000, 8'h11, 4'h0, 5'b10001, 8'hFF);
    add("idle", C_IDLE, 16'h0, 8'h0, 4'h0, 5'b10001, 8'hFF);
    add("iord_w1", C_IORD, 16'h0010, 8'h0, 4'h0, 5'b00001, 8'hA7);
    add("iord_w2", C_IORD, 16'h0010, 8'h0, 4'h0, 5'b00001, 8'hA7);
    add("iord_pulse", C_IORD, 16'h0010, 8'h0, 4'h0, 5'b10101, 8'hA7);
    add("iord_hold", C_IORD, 16'h0010, 8'h0, 4'h0, 5'b10001, 8'hA7);
    add("idle", C_IDLE, 16'h0, 8'h0, 4'h0, 5'b10001, 8'hFF);
    add("iowr_w1", C_IOWR, 16'h0020, 8'h33, 4'h0, 5'b00001, 8'hFF);
    add("iowr_w2", C_IOWR, 16'h0020, 8'h33, 4'h0, 5'b00001, 8'hFF);
    add("iowr_pulse", C_IOWR, 16'h0020, 8'h33, 4'h0, 5'b10011, 8'hFF);
    add("iowr_hold", C_IOWR, 16'h0020, 8'h33, 4'h0, 5'b10001, 8'hFF);
    add("idle", C_IDLE, 16'h0, 8'h0, 4'h0, 5'b10001, 8'hFF);
    add("iord_early", C_IORD, 16'h0010, 8'h0, 4'h0, 5'b00001, 8'hA7);
    add("early_cancel", C_IDLE, 16'h0, 8'h0, 4'h0, 5'b10001, 8'hFF);
    add("early_cancel2", C_IDLE, 16'h0, 8'h0, 4'h0, 5'b10001, 8'hFF);
    // mask = 0x0F
    add("mask_w1", C_IOWR, 16'h00F0, 8'h0F, 4'h0, 5'b00001, 8'hFF);
    add("mask_w2", C_IOWR, 16'h00F0, 8'h0F, 4'h0, 5'b00001, 8'hFF);
    add("mask_noiowr", C_IOWR, 16'h00F0, 8'h0F, 4'h0, 5'b10001, 8'hFF);
    add("idle", C_IDLE, 16'h0, 8'h0, 4'h0, 5'b10001, 8'hFF);
    add("irq2_edge", C_IDLE, 16'h0, 8'h0, 4'b0100, 5'b10001, 8'hFF);
    add("irq1_edge", C_IDLE, 16'h0, 8'h0, 4'b0110, 5'b10000, 8'hFF);
    add("int_asserted", C_IDLE, 16'h0, 8'h0, 4'b0110, 5'b10000, 8'hFF);
    add("pend_rd1", C_IORD, 16'h00F0, 8'h0, 4'b0110, 5'b00000, 8'h06);
    add("pend_rd2", C_IORD, 16'h00F0, 8'h0, 4'b0110, 5'b00000, 8'h06);
    add("pend_noiord", C_IORD, 16'h00F0, 8'h0, 4'b0110, 5'b10000, 8'h06);
    add("idle", C_IDLE, 16'h0, 8'h0, 4'b0110, 5'b10000, 8'hFF);
    add("inta1_w1", C_INTA, 16'h0, 8'h0, 4'b0110, 5'b00000, 8'h82);
    add("inta1_w2", C_INTA, 16'h0, 8'h0, 4'b0110, 5'b00000, 8'h82);
    add("inta1_vec", C_INTA, 16'h0, 8'h0, 4'b0110, 5'b10000, 8'h82);
    add("inta1_end", C_IDLE, 16'h0, 8'h0, 4'b0110, 5'b10000, 8'hFF);
    add("irq2_still", C_IDLE, 16'h0, 8'h0, 4'b0110, 5'b10000, 8'hFF);
    add("pend_rd_after", C_IORD, 16'h00F0, 8'h0, 4'b0110, 5'b00000, 8'h04);
    add("pend_rd_after", C_IORD, 16'h00F0, 8'h0, 4'b0110, 5'b00000, 8'h04);
    add("pend_rd_after", C_IORD, 16'h00F0, 8'h0, 4'b0110, 5'b10000, 8'h04);
    add("idle", C_IDLE, 16'h0, 8'h0, 4'b0110, 5'b10000, 8'hFF);
    add("inta2_w1", C_INTA, 16'h0, 8'h0, 4'b0110, 5'b00000, 8'h84);
    add("inta2_w2", C_INTA, 16'h0, 8'h0, 4'b0110, 5'b00000, 8'h84);
    add("inta2_vec", C_INTA, 16'h0, 8'h0, 4'b0110, 5'b10000, 8'h84);
    add("inta2_end", C_IDLE, 16'h0, 8'h0, 4'b0110, 5'b10000, 8'hFF);
    add("int_released", C_IDLE, 16'h0, 8'h0, 4'b0110, 5'b10001, 8'hFF);
    add("irq_low", C_IDLE, 16'h0, 8'h0, 4'b0000, 5'b10001, 8'hFF);
    // mask = 0
    add("mask0_w1", C_IOWR, 16'h00F0, 8'h00, 4'h0, 5'b00001, 8'hFF);
    add("mask0_w2", C_IOWR, 16'h00F0, 8'h00, 4'h0, 5'b00001, 8'hFF);
    add("mask0_w3", C_IOWR, 16'h00F0, 8'h00, 4'h0, 5'b10001, 8'hFF);
    add("idle", C_IDLE, 16'h0, 8'h0, 4'h0, 5'b10001, 8'hFF);
    add("irq0_masked", C_IDLE, 16'h0, 8'h0, 4'b0001, 5'b10001, 8'hFF);
    add("irq0_masked2", C_IDLE, 16'h0, 8'h0, 4'b0001, 5'b10001, 8'hFF);
    add("pend_masked", C_IORD, 16'h00F0, 8'h0, 4'b0001, 5'b00001, 8'h01);
    add("pend_masked", C_IORD, 16'h00F0, 8'h0, 4'b0001, 5'b00001, 8'h01);
    add("pend_masked", C_IORD, 16'h00F0, 8'h0, 4'b0001, 5'b10001, 8'h01);
    add("idle", C_IDLE, 16'h0, 8'h0, 4'b0001, 5'b10001, 8'hFF);
    add("irq0_low", C_IDLE, 16'h0, 8'h0, 4'b0000, 5'b10001, 8'hFF);
    // unmask: int_n falls the cycle after the write lands
    add("unmask_w1", C_IOWR, 16'h00F0, 8'h0F, 4'h0, 5'b00001, 8'hFF);
    add("unmask_w2", C_IOWR, 16'h00F0, 8'h0F, 4'h0, 5'b00001, 8'hFF);
    add("unmask_w3", C_IOWR, 16'h00F0, 8'h0F, 4'h0, 5'b10001, 8'hFF);
    add("unmask_int", C_IDLE, 16'h0, 8'h0, 4'h0, 5'b10000, 8'hFF);
    add("inta0_w1", C_INTA, 16'h0, 8'h0, 4'h0, 5'b00000, 8'h80);
    add("inta0_w2", C_INTA, 16'h0, 8'h0, 4'h0, 5'b00000, 8'h80);
    add("inta0_vec", C_INTA, 16'h0, 8'h0, 4'h0, 5'b10000, 8'h80);
    add("inta0_end", C_IDLE, 16'h0, 8'h0, 4'h0, 5'b10000, 8'hFF);
    add("irq1_rise", C_IDLE, 16'h0, 8'h0, 4'b0010, 5'b10001, 8'hFF);
    add("irq1_int", C_IDLE, 16'h0, 8'h0, 4'b0010, 5'b10000, 8'hFF);
    add("inta3_w1", C_INTA, 16'h0, 8'h0, 4'b0000, 5'b00000, 8'h82);
    add("inta3_w2", C_INTA, 16'h0, 8'h0, 4'b0000, 5'b00000, 8'h82);
    add("inta3_vec", C_INTA, 16'h0, 8'h0, 4'b0000, 5'b10000, 8'h82);
    add("inta3_end_edge", C_IDLE, 16'h0, 8'h0, 4'b0010, 5'b10000, 8'hFF);
    add("edge_wins", C_IDLE, 16'h0, 8'h0, 4'b0010, 5'b10000, 8'hFF);
    add("edge_wins_rd", C_IORD, 16'h00F0, 8'h0, 4'b0010, 5'b00000, 8'h02);
    add("edge_wins_rd", C_IORD, 16'h00F0, 8'h0, 4'b0010, 5'b00000, 8'h02);
    add("edge_wins_rd", C_IORD, 16'h00F0, 8'h0, 4'b0010, 5'b10000, 8'h02);
    add("idle", C_IDLE, 16'h0, 8'h0, 4'b0010, 5'b10000, 8'hFF);
    add("rst_pre_iord", C_IORD, 16'h0010, 8'h0, 4'b0010, 5'b00000, 8'hA7);

    // ---------------- reset and stretcher ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_reset_n", {7'b0, core_reset_n}, 8'h00);
    chk("rst_wait_n", {7'b0, wait_n}, 8'h01);
    chk("rst_int_n", {7'b0, int_n}, 8'h01);
    chk("rst_strobes", {5'b0, mem_we, io_rd, io_wr}, 8'h00);
    chk("rst_cpu_di", cpu_di, 8'hFF);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stretch_rst_k%0d", k), {7'b0, core_reset_n}, (k == 8) ? 8'h01 : 8'h00);
    end
    btn_rst_n = 1'b0;
    @(posedge clk); #1;
    btn_rst_n = 1'b1;
    chk("btn_reload", {7'b0, core_reset_n}, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stretch_btn_k%0d", k), {7'b0, core_reset_n}, (k == 8) ? 8'h01 : 8'h00);
    end

    // ---------------- table ----------------
    foreach (tbl[i]) apply(tbl[i]);

    // ---------------- reset in the middle of a waited IO read ----------------
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_wait_n", {7'b0, wait_n}, 8'h01);
    chk("midrst_io_rd", {7'b0, io_rd}, 8'h00);
    @(posedge clk); #1;
    chk("midrst_core_reset_n", {7'b0, core_reset_n}, 8'h00);
    chk("midrst_int_n", {7'b0, int_n}, 8'h01);
    chk("midrst_wait_n2", {7'b0, wait_n}, 8'h01);
    reset = 1'b0;
    {mreq_n, iorq_n, rd_n, wr_n, m1_n} = C_IDLE;
    @(posedge clk); #1;
    chk("scoreboard_drained", 8'(sb.size()), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
